// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM among drawing engines,
// with burst locking, a burst cap and a 1-cycle tagged response path.
module sprite_rom_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 24,
  parameter int MAX_BURST = 24,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data
);

  localparam int BC_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ARB,
    LOCKED
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [BC_W-1:0]   burst_q, burst_d;
  logic              v_q;
  logic [ID_W-1:0]   id_q;

  logic              arb_found;
  logic [ID_W-1:0]   arb_idx;
  logic              gnt_vld;
  logic              gnt_act;
  logic [ID_W-1:0]   gnt_idx;
  logic [BC_W-1:0]   burst_inc;

  function automatic logic [ID_W-1:0] nxt_ptr(
    input logic [ID_W-1:0] i
  );
    if (int'(i) == NUM_REQ - 1)
      return '0;
    return i + 1'b1;
  endfunction

  // Rotating priority scan starting at rr_ptr_q
  always_comb begin
    logic [ID_W:0] pos;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (pos >= (ID_W+1)'(NUM_REQ))
        pos = pos - (ID_W+1)'(NUM_REQ);
      if (!arb_found && req[pos[ID_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = pos[ID_W-1:0];
      end
    end
  end

  assign burst_inc = burst_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    burst_d  = burst_q;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    unique case (state_q)
      ARB: begin
        if (arb_found) begin
          gnt_vld  = 1'b1;
          gnt_idx  = arb_idx;
          rr_ptr_d = nxt_ptr(arb_idx);
          if (req_lock[arb_idx] && (MAX_BURST > 1)) begin
            state_d = LOCKED;
            owner_d = arb_idx;
            burst_d = BC_W'(1);
          end
        end
      end
      LOCKED: begin
        if (req[owner_q]) begin
          gnt_vld  = 1'b1;
          gnt_idx  = owner_q;
          rr_ptr_d = nxt_ptr(owner_q);
          burst_d  = burst_inc;
          if (!req_lock[owner_q] ||
              burst_inc >= BC_W'(MAX_BURST)) begin
            state_d = ARB;
            burst_d = '0;
          end
        end else begin
          state_d = ARB;
          burst_d = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Outputs held quiet while reset is asserted
  assign gnt_act  = gnt_vld & Reset_n;
  assign gnt      = gnt_act ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign rom_addr = gnt_act ? req_addr[gnt_idx*ADDR_W +: ADDR_W]
                            : '0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      burst_q  <= '0;
      v_q      <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      burst_q  <= burst_d;
      v_q      <= gnt_act;
      id_q     <= gnt_act ? gnt_idx : '0;
    end
  end

  assign rsp_valid = v_q;
  assign rsp_id    = id_q;
  assign rsp_data  = v_q ? rom_data : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: default instance plus a
// MAX_BURST=4 instance for the burst-cap rotation.
module tb_sprite_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, req_lock;
  logic [35:0] req_addr;

  logic [3:0]  gnt_a, gnt_b;
  logic [8:0]  rom_addr_a, rom_addr_b;
  logic [23:0] rom_a, rom_b;
  logic        rv_a, rv_b;
  logic [1:0]  rid_a, rid_b;
  logic [23:0] rd_a, rd_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_f(input logic [8:0] a);
    return {6'h2A, a, ~a};
  endfunction

  always @(posedge clk) begin
    rom_a <= rom_f(rom_addr_a);
    rom_b <= rom_f(rom_addr_b);
  end

  sprite_rom_arbiter u_dut (
    .Clk(clk), .Reset_n(rst_n),
    .req(req), .req_lock(req_lock), .req_addr(req_addr),
    .gnt(gnt_a), .rom_addr(rom_addr_a), .rom_data(rom_a),
    .rsp_valid(rv_a), .rsp_id(rid_a), .rsp_data(rd_a)
  );

  sprite_rom_arbiter #(.MAX_BURST(4)) u_cap (
    .Clk(clk), .Reset_n(rst_n),
    .req(req), .req_lock(req_lock), .req_addr(req_addr),
    .gnt(gnt_b), .rom_addr(rom_addr_b), .rom_data(rom_b),
    .rsp_valid(rv_b), .rsp_id(rid_b), .rsp_data(rd_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    req_lock = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    req_addr = {9'd40, 9'd30, 9'd20, 9'd10};
    req      = 4'b1111;
    req_lock = '0;
    rst_n    = 1'b0;

    // 1: outputs quiet in reset
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt_a), 32'h0);
    chk("rst_addr", 32'(rom_addr_a), 32'h0);
    chk("rst_rv", 32'(rv_a), 32'h0);
    chk("rst_id", 32'(rid_a), 32'h0);
    chk("rst_data", 32'(rd_a), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 2: strict rotation with rr_ptr wrap
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("rr_gnt%0d", c), 32'(gnt_a),
          32'(4'b0001 << (c % 4)));
      chk($sformatf("rr_addr%0d", c), 32'(rom_addr_a),
          32'(10 * (c % 4 + 1)));
      chk($sformatf("rr_rv%0d", c), 32'(rv_a), 32'(c > 0));
      if (c > 0) begin
        chk($sformatf("rr_id%0d", c), 32'(rid_a),
            32'((c - 1) % 4));
        chk($sformatf("rr_dat%0d", c), 32'(rd_a),
            32'(rom_f(9'(10 * ((c - 1) % 4 + 1)))));
      end
      @(posedge clk); #1;
    end

    // 3: 24-beat locked burst by requester 2, requester 0 blocked
    do_reset();
    for (int c = 0; c < 25; c++) begin
      req      = (c == 0) ? 4'b0100 :
                 (c == 24) ? 4'b0001 : 4'b0101;
      req_lock = (c == 0 || c == 23 || c == 24) ?
                 ((c == 0) ? 4'b0100 : 4'b0000) : 4'b0100;
      @(negedge clk);
      chk($sformatf("bst_gnt%0d", c), 32'(gnt_a),
          (c == 24) ? 32'h1 : 32'h4);
      if (c == 1)
        chk("bst_id", 32'(rid_a), 32'h2);
      @(posedge clk); #1;
    end

    // 4: cap of 4 beats, then requester 3 gets one slot
    do_reset();
    req      = 4'b1010;
    req_lock = 4'b0010;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk($sformatf("cap_gnt%0d", c), 32'(gnt_b),
          (c % 5 < 4) ? 32'h2 : 32'h8);
      @(posedge clk); #1;
    end

    // 5: single request latency at top address
    do_reset();
    req_addr = {9'd40, 9'd30, 9'd479, 9'd10};
    @(posedge clk); #1;
    req = 4'b0010;
    @(negedge clk);
    chk("lat_gnt", 32'(gnt_a), 32'h2);
    chk("lat_addr", 32'(rom_addr_a), 32'd479);
    @(posedge clk); #1;
    req = 4'b0000;
    @(negedge clk);
    chk("lat_gnt0", 32'(gnt_a), 32'h0);
    chk("lat_rv", 32'(rv_a), 32'h1);
    chk("lat_id", 32'(rid_a), 32'h1);
    chk("lat_dat", 32'(rd_a), 32'(rom_f(9'd479)));
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_rv0", 32'(rv_a), 32'h0);
    chk("lat_dat0", 32'(rd_a), 32'h0);

    // 6: async reset in the middle of a lock
    do_reset();
    req_addr = {9'd40, 9'd30, 9'd20, 9'd10};
    req      = 4'b0100;
    req_lock = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mid_gnt%0d", c), 32'(gnt_a), 32'h4);
      @(posedge clk); #1;
    end
    req = 4'b0101;
    @(negedge clk);
    chk("mid_gnt_lk", 32'(gnt_a), 32'h4);
    chk("mid_rv", 32'(rv_a), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rv_rst", 32'(rv_a), 32'h0);
    chk("mid_gnt_rst", 32'(gnt_a), 32'h0);
    chk("mid_dat_rst", 32'(rd_a), 32'h0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    req_lock = 4'b0000;
    @(negedge clk);
    chk("mid_rv_post", 32'(rv_a), 32'h0);
    chk("mid_gnt_post", 32'(gnt_a), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_gnt_nxt", 32'(gnt_a), 32'h4);
    chk("mid_id_nxt", 32'(rid_a), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
